// File: rtl/demux_1to4_case.sv
// Registered 1-to-4 demultiplexer: sel steers i to one of o0..o3, with a one-hot valid vector.
// Build option DEMUX_CASE_HOLD_EN: outputs that are not loaded hold their value instead of clearing.
module demux_1to4_case #(
  parameter int width = 8,
  parameter int snum  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] i,
  input  logic [snum-1:0]  sel,
  input  logic             en,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [3:0]       o_vld
);

  generate
    if (snum != 2) begin : g_bad_snum
      $error("demux_1to4_case: snum must be 2");
    end
    if (width < 4) begin : g_bad_width
      $error("demux_1to4_case: width must be >= 4");
    end
  endgenerate

  logic [width-1:0] o0_nxt, o1_nxt, o2_nxt, o3_nxt;
  logic [3:0]       vld_nxt;

  always_comb begin
`ifdef DEMUX_CASE_HOLD_EN
    o0_nxt = o0;
    o1_nxt = o1;
    o2_nxt = o2;
    o3_nxt = o3;
`else
    o0_nxt = '0;
    o1_nxt = '0;
    o2_nxt = '0;
    o3_nxt = '0;
`endif
    vld_nxt = 4'b0000;
    if (en) begin
      case (sel)
        2'd0: begin o0_nxt = i; vld_nxt = 4'b0001; end
        2'd1: begin o1_nxt = i; vld_nxt = 4'b0010; end
        2'd2: begin o2_nxt = i; vld_nxt = 4'b0100; end
        2'd3: begin o3_nxt = i; vld_nxt = 4'b1000; end
        // Unknown select bits: route nothing and clear every channel, even in hold mode.
        default: begin
          o0_nxt  = '0;
          o1_nxt  = '0;
          o2_nxt  = '0;
          o3_nxt  = '0;
          vld_nxt = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o0    <= '0;
      o1    <= '0;
      o2    <= '0;
      o3    <= '0;
      o_vld <= 4'b0000;
    end else begin
      o0    <= o0_nxt;
      o1    <= o1_nxt;
      o2    <= o2_nxt;
      o3    <= o3_nxt;
      o_vld <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_demux_1to4_case.sv
// Bench for demux_1to4_case: directed vector table, an unknown-select case and a randomized run
// against a channel-array reference model.
module tb_demux_1to4_case;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i;
  logic [1:0] sel;
  logic       en;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] o_vld;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_o [4];
  logic [3:0] m_vld;

  demux_1to4_case #(.width(8), .snum(2)) dut (
    .clk(clk), .rst(rst), .i(i), .sel(sel), .en(en),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_vld(o_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic [1:0] s;
    logic       e;
    logic [7:0] x0, x1, x2, x3;
    logic [3:0] xv;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: channel k receives the word when selected, otherwise clears (or keeps it in hold builds).
  task automatic model_update(input logic r, input logic [7:0] d, input logic [1:0] s, input logic e);
    if (r) begin
      foreach (m_o[k]) m_o[k] = 8'h00;
      m_vld = 4'b0000;
    end else if (e && $isunknown(s)) begin
      foreach (m_o[k]) m_o[k] = 8'h00;
      m_vld = 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (e && int'(s) == k) m_o[k] = d;
`ifndef DEMUX_CASE_HOLD_EN
        else m_o[k] = 8'h00;
`endif
      end
      m_vld = e ? (4'b0001 << s) : 4'b0000;
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic [1:0] s, input logic e);
    @(negedge clk);
    rst = r; i = d; sel = s; en = e;
    @(posedge clk);
    #1;
    model_update(rst, i, sel, en);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".o0"}, o0, m_o[0]);
    chk({tag, ".o1"}, o1, m_o[1]);
    chk({tag, ".o2"}, o2, m_o[2]);
    chk({tag, ".o3"}, o3, m_o[3]);
    chk({tag, ".vld"}, {4'h0, o_vld}, {4'h0, m_vld});
  endtask

  initial begin
    vec_t tbl [13];
    tbl[0]  = '{1'b1, 8'hFF, 2'd2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000};
    tbl[1]  = '{1'b1, 8'hFF, 2'd2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000};
    tbl[2]  = '{1'b0, 8'hA0, 2'd0, 1'b1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001};
    tbl[3]  = '{1'b0, 8'hB0, 2'd1, 1'b1, 8'h00, 8'hB0, 8'h00, 8'h00, 4'b0010};
    tbl[4]  = '{1'b0, 8'hC0, 2'd2, 1'b1, 8'h00, 8'h00, 8'hC0, 8'h00, 4'b0100};
    tbl[5]  = '{1'b0, 8'hD0, 2'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'hD0, 4'b1000};
    tbl[6]  = '{1'b0, 8'h55, 2'd1, 1'b1, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0010};
    tbl[7]  = '{1'b0, 8'hAA, 2'd1, 1'b1, 8'h00, 8'hAA, 8'h00, 8'h00, 4'b0010};
    tbl[8]  = '{1'b0, 8'hC0, 2'd2, 1'b1, 8'h00, 8'h00, 8'hC0, 8'h00, 4'b0100};
    tbl[9]  = '{1'b0, 8'hC0, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000};
    tbl[10] = '{1'b0, 8'h3C, 2'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h3C, 4'b1000};
    tbl[11] = '{1'b1, 8'h3C, 2'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000};
    tbl[12] = '{1'b0, 8'h77, 2'd0, 1'b1, 8'h77, 8'h00, 8'h00, 8'h00, 4'b0001};

    rst = 1'b1; i = 8'h00; sel = 2'd0; en = 1'b0;
    foreach (m_o[k]) m_o[k] = 8'h00;
    m_vld = 4'b0000;

    for (int n = 0; n < 13; n++) begin
      step(tbl[n].r, tbl[n].d, tbl[n].s, tbl[n].e);
`ifdef DEMUX_CASE_HOLD_EN
      chk_model($sformatf("vec%0d", n));
`else
      chk($sformatf("vec%0d.o0", n), o0, tbl[n].x0);
      chk($sformatf("vec%0d.o1", n), o1, tbl[n].x1);
      chk($sformatf("vec%0d.o2", n), o2, tbl[n].x2);
      chk($sformatf("vec%0d.o3", n), o3, tbl[n].x3);
      chk($sformatf("vec%0d.vld", n), {4'h0, o_vld}, {4'h0, tbl[n].xv});
`endif
    end

    // Unknown select: a 4-state simulator sees X and expects all-clear; a 2-state one routes the resolved value.
    step(1'b0, 8'h12, 2'bxx, 1'b1);
    chk_model("selx");

    // Hold/clear after en drops from a loaded channel, then mid-stream reset and recovery.
    step(1'b0, 8'hC0, 2'd2, 1'b1);
    step(1'b0, 8'h00, 2'd1, 1'b0);
    chk_model("en_off");
    step(1'b1, 8'h99, 2'd3, 1'b1);
    chk_model("mid_rst");
    step(1'b0, 8'h77, 2'd0, 1'b1);
    chk_model("post_rst");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
      chk_model($sformatf("rnd%0d", n));
      checks++;
      if (!$onehot0(o_vld)) begin
        failures++;
        $display("FAIL rnd%0d.onehot actual=%b required=onehot0", n, o_vld);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1to4_case.md
Name: demux_1to4_case

Overview:
Registered 1-to-4 demultiplexer for a WIDTH-bit data word. A 2-bit select, decoded with a case statement, steers input i to exactly one of four outputs o0..o3. Used as a routing stage in the data-path blocks. Outputs are registered on clk, with a one-hot valid vector alongside.

Parameters:
width, 8, data width in bits of i and o0..o3 (legal: >= 4)
snum, 2, select width in bits; fixed at 2 for this 4-output block (any other value is an elaboration error)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
i  input  width  data word to route
sel  input  snum  output select: 0->o0, 1->o1, 2->o2, 3->o3
en  input  1  route enable; 1 = load the selected output this cycle
o0  output  width  routed data, channel 0 (registered)
o1  output  width  routed data, channel 1 (registered)
o2  output  width  routed data, channel 2 (registered)
o3  output  width  routed data, channel 3 (registered)
o_vld  output  4  one-hot valid; bit n set = on is carrying routed data (registered)

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset: when rst=1 at a rising clk edge, o0..o3 = 0 and o_vld = 4'b0000. Reset overrides en and sel.
- Latency is 1 cycle. Values of i, sel and en sampled at edge N appear on the outputs after edge N.
- en=1, sel=k (k in 0..3): ok <= i; every other output <= 0; o_vld <= 1<<k.
- en=0: o0..o3 <= 0; o_vld <= 0.
- Decode is a full case on sel. If sel has any X/Z bit, the default branch applies: all outputs <= 0 and o_vld <= 0.
- No width arithmetic. Data passes bit-exact; no truncation or extension.
- Back-to-back selects are allowed every cycle. A change of sel moves the data to the new output in the next cycle, and the old output clears in that same cycle.
- Same sel on consecutive cycles: the output follows i each cycle.
- Reset asserted mid-stream: outputs clear at the next edge. The first edge after rst falls routes normally.
- At most one o_vld bit is ever set.

Optional Feature:
Macro DEMUX_CASE_HOLD_EN.
- Defined: non-selected outputs hold their previous registered value instead of clearing to 0.
  - en=0 holds all four outputs.
  - o_vld is unaffected and still one-hot or zero per the rules above.
  - Reset still clears everything.
- Not defined: clear-to-zero behaviour as specified in Behaviour.

Test Plan:
1. rst=1 for 2 cycles with i=8'hFF, sel=2, en=1 -> o0..o3=0, o_vld=0000 throughout.
2. en=1, each for one cycle: i=8'hA0/sel=0, then 8'hB0/sel=1, then 8'hC0/sel=2, then 8'hD0/sel=3 -> one cycle later o0=A0 (others 0, o_vld=0001), then o1=B0 (0010), o2=C0 (0100), o3=D0 (1000).
3. sel=1, en=1, i toggles 8'h55 -> 8'hAA on consecutive cycles -> o1 follows 55 then AA with 1-cycle lag; o0/o2/o3 stay 0.
4. After o2=8'hC0, drive en=0 -> next cycle all outputs 0, o_vld=0000. With DEMUX_CASE_HOLD_EN defined, o2 stays C0 and o_vld=0000.
5. sel=2'bx, en=1, i=8'h12 -> next cycle all outputs 0, o_vld=0000.
6. Streaming sel=3, i=8'h3C, then rst=1 for one cycle -> after the reset edge all outputs 0. Next edge with rst=0, sel=0, i=8'h77 -> o0=77, o_vld=0001.
